// File: rtl/amm_rdwr_pkg.sv
// -----------------------------------------------------------------------------
// amm_rdwr_pkg
// Shared types and constants for the pushbutton-driven Avalon-MM read/write
// master (amm_rdwr_master) and its key debouncer.
//   state_e        : master FSM state encoding (IDLE, WR, RD_REQ, RD_WAIT)
//   TIMEOUT_LIMIT  : RD_WAIT cycle count after which a read is abandoned
//                    (only used when AMM_RDWR_TIMEOUT_EN is defined)
//   TIMEOUT_CODE   : value shown on the display after an abandoned read
// -----------------------------------------------------------------------------
package amm_rdwr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } state_e;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'hFFFF;
  localparam logic [31:0] TIMEOUT_CODE  = 32'hDEADBEEF;

endpackage : amm_rdwr_pkg

// File: rtl/amm_rdwr_master_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronises an asynchronous active-low pushbutton into the clk domain,
// filters it, and emits a single-cycle pulse when the filtered level falls.
//
// Ports:
//   clk    in   system clock (rising edge)
//   reset  in   synchronous, active-high; filtered level returns to 1
//   n_key  in   raw asynchronous active-low button
//   press  out  one-cycle pulse on a debounced 1->0 transition
//
// Parameter:
//   DEBOUNCE_CYCLES  number of consecutive cycles the synchronised input must
//                    disagree with the current filtered level before the
//                    filtered level follows it.
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic n_key,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // The counter only runs while the synchronised input disagrees with the
  // filtered level; any bounce back to agreement restarts it from zero, so a
  // glitch shorter than DEBOUNCE_CYCLES never reaches the filtered level.
  always_comb begin
    sync1_d = n_key;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule : key_debounce

// File: rtl/amm_rdwr_master.sv
// -----------------------------------------------------------------------------
// amm_rdwr_master
// Board-level Avalon-MM master driven by switches and a pushbutton. A press
// either latches a word address from the switches, or issues a single write
// (switch value as data) or a single pipelined read to that address. The last
// written / read value (or latched address) is presented for a 7-seg display.
//
// Ports:
//   clk                in   single clock, rising edge
//   reset              in   synchronous, active-high
//   rdwr_cntl          in   0 = write, 1 = read
//   n_action           in   asynchronous active-low pushbutton
//   add_data_sel       in   0 = press latches address, 1 = press issues access
//   rdwr_address[15:0] in   switches: word address or write data
//   display_data[31:0] out  value for the display
//   avm_address        out  byte address = BASE_ADDR + 4*addr_reg (wraps)
//   avm_read/avm_write out  registered Avalon commands, never both high
//   avm_byteenable     out  all ones
//   avm_writedata      out  write data
//   avm_readdata       in   read data
//   avm_readdatavalid  in   read response strobe (honoured only in RD_WAIT)
//   avm_waitrequest    in   slave stall
//
// Optional feature (macro AMM_RDWR_TIMEOUT_EN): a 16-bit watchdog in RD_WAIT
// abandons a read after TIMEOUT_LIMIT cycles and shows TIMEOUT_CODE.
// -----------------------------------------------------------------------------
module amm_rdwr_master
  import amm_rdwr_pkg::*;
#(
  parameter int          ADDRESSWIDTH    = 28,
  parameter int          DATAWIDTH       = 32,
  parameter int unsigned BASE_ADDR       = 0,
  parameter int          DEBOUNCE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rdwr_cntl,
  input  logic                      n_action,
  input  logic                      add_data_sel,
  input  logic [15:0]               rdwr_address,
  output logic [31:0]               display_data,
  output logic [ADDRESSWIDTH-1:0]   avm_address,
  output logic                      avm_read,
  output logic                      avm_write,
  output logic [DATAWIDTH/8-1:0]    avm_byteenable,
  output logic [DATAWIDTH-1:0]      avm_writedata,
  input  logic [DATAWIDTH-1:0]      avm_readdata,
  input  logic                      avm_readdatavalid,
  input  logic                      avm_waitrequest
);

  state_e                 state_q, state_d;
  logic [15:0]            addr_reg_q, addr_reg_d;
  logic [DATAWIDTH-1:0]   writedata_q, writedata_d;
  logic [31:0]            display_q, display_d;
  logic                   avm_read_q, avm_read_d;
  logic                   avm_write_q, avm_write_d;
  logic                   key_press;
  logic                   timeout_hit;

  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (clk),
    .reset (reset),
    .n_key (n_action),
    .press (key_press)
  );

`ifdef AMM_RDWR_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;

  // Counts cycles spent in RD_WAIT; restarts from zero on every entry.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == RD_WAIT) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
  end

  // Fires on the TIMEOUT_LIMIT-th RD_WAIT cycle; a valid in that same cycle
  // still wins so real data is never overwritten by the timeout code.
  assign timeout_hit = (state_q == RD_WAIT) && !avm_readdatavalid &&
                       (to_cnt_q == (TIMEOUT_LIMIT - 16'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; presses are only acted on in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (key_press && add_data_sel) begin
          state_d = rdwr_cntl ? RD_REQ : WR;
        end
      end
      WR: begin
        if (!avm_waitrequest) state_d = IDLE;
      end
      RD_REQ: begin
        if (!avm_waitrequest) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (avm_readdatavalid || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic. Commands are decoded from the next state and
  // registered, so they rise the cycle after the press and drop the cycle
  // after acceptance, and are mutually exclusive by construction.
  always_comb begin
    addr_reg_d  = addr_reg_q;
    writedata_d = writedata_q;
    display_d   = display_q;
    case (state_q)
      IDLE: begin
        if (key_press) begin
          if (!add_data_sel) begin
            addr_reg_d = rdwr_address;
            display_d  = {16'h0000, rdwr_address};
          end else if (!rdwr_cntl) begin
            writedata_d = DATAWIDTH'({16'h0000, rdwr_address});
          end
        end
      end
      WR: begin
        if (!avm_waitrequest) display_d = 32'(writedata_q);
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          display_d = 32'(avm_readdata);
        end else if (timeout_hit) begin
          display_d = TIMEOUT_CODE;
        end
      end
      default: ;
    endcase
    avm_write_d = (state_d == WR);
    avm_read_d  = (state_d == RD_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg_q  <= '0;
      writedata_q <= '0;
      display_q   <= '0;
      avm_read_q  <= 1'b0;
      avm_write_q <= 1'b0;
    end else begin
      addr_reg_q  <= addr_reg_d;
      writedata_q <= writedata_d;
      display_q   <= display_d;
      avm_read_q  <= avm_read_d;
      avm_write_q <= avm_write_d;
    end
  end

  // Word address to byte address, offset by BASE_ADDR, wrapping at the bus width.
  assign avm_address    = ADDRESSWIDTH'(BASE_ADDR) + ADDRESSWIDTH'({addr_reg_q, 2'b00});
  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_byteenable = '1;
  assign avm_writedata  = writedata_q;
  assign display_data   = display_q;

endmodule : amm_rdwr_master
